// File: rtl/disp_hex_capture_if.sv
// Display-side bus for the seven-segment capture block: scanned anode/segment
// inputs and the decoded digit, flag and strobe outputs.
interface disp_hex_capture_if;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [3:0] hex3;
  logic [3:0] hex2;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic [3:0] dp_out;
  logic [3:0] digit_valid;
  logic [3:0] bad_code;
  logic       frame_done;
  logic       stall;

  modport master (
    output an, sseg,
    input  hex3, hex2, hex1, hex0, dp_out, digit_valid, bad_code, frame_done, stall
  );

  modport slave (
    input  an, sseg,
    output hex3, hex2, hex1, hex0, dp_out, digit_valid, bad_code, frame_done, stall
  );
endinterface

// File: rtl/disp_hex_capture.sv
// Recovers hex digits from a 4-digit time-multiplexed seven-segment scan once
// each anode slot has held steady for STABLE_CYCLES+1 samples.
module disp_hex_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned STALL_W       = 20
) (
  input logic               clk,
  input logic               reset,
  disp_hex_capture_if.slave bus
);
  localparam logic [7:0]         CNT_FIRE  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]         CNT_MAX   = 8'(STABLE_CYCLES);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [11:0]        r_s;
  logic [7:0]         r_cnt;
  logic [3:0]         r_hex [4];
  logic [3:0]         r_dp;
  logic [3:0]         r_valid;
  logic [3:0]         r_bad;
  logic [3:0]         r_seen;
  logic               r_frame;
  logic               r_stall;
  logic [STALL_W-1:0] r_stall_cnt;

  logic [11:0]        w_in;
  logic               w_same;
  logic               w_fire;
  logic               w_slot_ok;
  logic [1:0]         w_idx;
  logic [3:0]         w_mask;
  logic [3:0]         w_seen_nxt;
  logic               w_legal;
  logic [3:0]         w_dec;
  logic [STALL_W-1:0] w_stall_inc;

  assign w_in   = {bus.an, bus.sseg};
  assign w_same = (w_in == r_s);
  // Count saturates at STABLE_CYCLES, so the fire compare below matches once per stable run.
  assign w_fire = w_same && (r_cnt == CNT_FIRE);

  always_comb begin
    w_slot_ok = 1'b0;
    w_idx     = 2'd0;
    case (bus.an)
      4'b1110: begin w_slot_ok = 1'b1; w_idx = 2'd0; end
      4'b1101: begin w_slot_ok = 1'b1; w_idx = 2'd1; end
      4'b1011: begin w_slot_ok = 1'b1; w_idx = 2'd2; end
      4'b0111: begin w_slot_ok = 1'b1; w_idx = 2'd3; end
      default: ;
    endcase
  end

  assign w_mask      = w_slot_ok ? (4'b0001 << w_idx) : 4'b0000;
  assign w_seen_nxt  = r_seen | w_mask;
  assign w_stall_inc = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + STALL_ONE;

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 4'h0;
    case (bus.sseg[6:0])
      7'h40: w_dec = 4'h0;
      7'h79: w_dec = 4'h1;
      7'h24: w_dec = 4'h2;
      7'h30: w_dec = 4'h3;
      7'h19: w_dec = 4'h4;
      7'h12: w_dec = 4'h5;
      7'h02: w_dec = 4'h6;
      7'h78: w_dec = 4'h7;
      7'h00: w_dec = 4'h8;
      7'h10: w_dec = 4'h9;
      7'h08: w_dec = 4'hA;
      7'h03: w_dec = 4'hB;
      7'h46: w_dec = 4'hC;
      7'h21: w_dec = 4'hD;
      7'h06: w_dec = 4'hE;
      7'h0E: w_dec = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s         <= {4'b1111, 8'hFF};
      r_cnt       <= '0;
      for (int unsigned i = 0; i < 4; i++) r_hex[i] <= '0;
      r_dp        <= '0;
      r_valid     <= '0;
      r_bad       <= '0;
      r_seen      <= '0;
      r_frame     <= 1'b0;
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_s <= w_in;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end

      r_frame <= 1'b0;
      if (w_fire && w_slot_ok) begin
        r_dp[w_idx]    <= ~bus.sseg[7];
        r_valid[w_idx] <= 1'b1;
        r_bad[w_idx]   <= ~w_legal;
        if (w_legal) r_hex[w_idx] <= w_dec;
        // The completing capture starts an empty frame rather than seeding the next one.
        if (w_seen_nxt == 4'b1111) begin
          r_seen  <= '0;
          r_frame <= 1'b1;
        end else begin
          r_seen <= w_seen_nxt;
        end
        r_stall_cnt <= '0;
        r_stall     <= 1'b0;
      end else begin
        r_stall_cnt <= w_stall_inc;
        r_stall     <= (w_stall_inc == '1);
      end
    end
  end

  assign bus.hex0        = r_hex[0];
  assign bus.hex1        = r_hex[1];
  assign bus.hex2        = r_hex[2];
  assign bus.hex3        = r_hex[3];
  assign bus.dp_out      = r_dp;
  assign bus.digit_valid = r_valid;
  assign bus.bad_code    = r_bad;
  assign bus.frame_done  = r_frame;
  assign bus.stall       = r_stall;
endmodule

// File: tb/tb_disp_hex_capture.sv
// Bench for disp_hex_capture: directed scenarios plus random scan traffic,
// both checked every cycle against a run-length/lookup-table model.
module tb_disp_hex_capture;
  localparam int SC    = 4;
  localparam int LIM_D = (1 << 20) - 1;
  localparam int LIM_S = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] r_an = 4'hF;
  logic [7:0] r_sseg = 8'hFF;

  int nchecks = 0;
  int nerr = 0;
  int fd_cnt = 0;

  disp_hex_capture_if bus_d ();
  disp_hex_capture_if bus_s ();

  assign bus_d.an   = r_an;
  assign bus_d.sseg = r_sseg;
  assign bus_s.an   = r_an;
  assign bus_s.sseg = r_sseg;

  disp_hex_capture #(.STABLE_CYCLES(SC), .STALL_W(20)) u_dut (
    .clk(clk), .reset(rst), .bus(bus_d)
  );
  disp_hex_capture #(.STABLE_CYCLES(SC), .STALL_W(4)) u_dut_s (
    .clk(clk), .reset(rst), .bus(bus_s)
  );

  always #5 clk = ~clk;

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic int glyph_val(input logic [6:0] g);
    for (int k = 0; k < 16; k++) if (glyphs[k] == g) return k;
    return -1;
  endfunction

  function automatic int lit_slot(input logic [3:0] a);
    int zeros = 0;
    int pos = -1;
    for (int k = 0; k < 4; k++) if (!a[k]) begin zeros++; pos = k; end
    return (zeros == 1) ? pos : -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: capture when the current sample completes a run of SC+1 identical samples.
  logic [3:0]  m_hex [4];
  logic [3:0]  m_dp, m_valid, m_bad, m_seen;
  logic        m_fd;
  logic [11:0] m_prev;
  int          m_run;
  int          m_stcnt;
  bit          m_live = 0;

  initial forever begin
    logic [11:0] cur;
    int slot;
    int g;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) m_hex[k] = 4'h0;
      m_dp = 0; m_valid = 0; m_bad = 0; m_seen = 0; m_fd = 0;
      m_prev = 12'hFFF; m_run = 1; m_stcnt = 0; m_live = 1;
    end else begin
      cur = {r_an, r_sseg};
      if (cur == m_prev) m_run++; else m_run = 1;
      m_prev = cur;
      m_fd = 0;
      slot = lit_slot(r_an);
      if (m_run == SC + 1 && slot >= 0) begin
        m_dp[slot] = ~r_sseg[7];
        m_valid[slot] = 1'b1;
        g = glyph_val(r_sseg[6:0]);
        if (g >= 0) begin m_hex[slot] = 4'(g); m_bad[slot] = 1'b0; end
        else m_bad[slot] = 1'b1;
        m_seen[slot] = 1'b1;
        m_stcnt = 0;
        if (m_seen == 4'hF) begin m_fd = 1; m_seen = 0; end
      end else if (m_stcnt < LIM_D) begin
        m_stcnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("hex0", bus_d.hex0, m_hex[0]);
      chk("hex1", bus_d.hex1, m_hex[1]);
      chk("hex2", bus_d.hex2, m_hex[2]);
      chk("hex3", bus_d.hex3, m_hex[3]);
      chk("dp_out", bus_d.dp_out, m_dp);
      chk("digit_valid", bus_d.digit_valid, m_valid);
      chk("bad_code", bus_d.bad_code, m_bad);
      chk("frame_done", bus_d.frame_done, m_fd);
      chk("stall", bus_d.stall, (m_stcnt == LIM_D));
      chk("s_hex", {bus_s.hex3, bus_s.hex2, bus_s.hex1, bus_s.hex0},
          {m_hex[3], m_hex[2], m_hex[1], m_hex[0]});
      chk("s_flags", {bus_s.dp_out, bus_s.digit_valid, bus_s.bad_code, bus_s.frame_done},
          {m_dp, m_valid, m_bad, m_fd});
      chk("s_stall", bus_s.stall, (m_stcnt >= LIM_S));
      if (bus_d.frame_done) fd_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s);
    r_an = a;
    r_sseg = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  logic [7:0] scan_seg [4] = '{8'h92, 8'hB0, 8'h24, 8'hF9};
  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int fd0;
    step(2);
    rst = 1'b0;
    chk("rst_valid", bus_d.digit_valid, 4'h0);
    chk("rst_frame", bus_d.frame_done, 1'b0);

    // Latency: update lands on the 5th edge after the value is applied.
    drive(4'b1110, 8'hC0);
    step(4);
    chk("lat_before", bus_d.digit_valid, 4'b0000);
    step(1);
    chk("lat_valid", bus_d.digit_valid, 4'b0001);
    chk("lat_hex0", bus_d.hex0, 4'h0);
    chk("lat_dp", bus_d.dp_out, 4'b0000);
    chk("lat_bad", bus_d.bad_code, 4'b0000);
    step(5);

    // Full scan "5","3","2","1" with dp on digit 2.
    fd0 = fd_cnt;
    for (int s = 0; s < 4; s++) begin
      drive(scan_an[s], scan_seg[s]);
      for (int k = 0; k < 8; k++) begin
        step(1);
        if (s == 3 && k == 3) chk("fd_early", bus_d.frame_done, 1'b0);
        if (s == 3 && k == 4) chk("fd_pulse", bus_d.frame_done, 1'b1);
        if (s == 3 && k == 5) chk("fd_end", bus_d.frame_done, 1'b0);
      end
    end
    chk("scan_hex", {bus_d.hex3, bus_d.hex2, bus_d.hex1, bus_d.hex0}, 16'h1235);
    chk("scan_dp", bus_d.dp_out, 4'b0100);
    chk("scan_fd_count", fd_cnt - fd0, 1);
    chk("model_hex3", m_hex[3], 4'h1);

    // Illegal glyph on digit 1, then a legal one.
    drive(4'b1101, 8'hFF);
    step(8);
    chk("bad_set", bus_d.bad_code, 4'b0010);
    chk("bad_hold", bus_d.hex1, 4'h3);
    drive(4'b1101, 8'hF9);
    step(8);
    chk("bad_clr", bus_d.bad_code, 4'b0000);
    chk("bad_hex1", bus_d.hex1, 4'h1);

    // Short glitch on slot 2, then blanked and multi-lit anodes.
    drive(4'b1110, 8'hC0);
    step(8);
    drive(4'b1011, 8'h80);
    step(3);
    drive(4'b1110, 8'hC0);
    step(8);
    chk("glitch_hex2", bus_d.hex2, 4'h2);
    chk("glitch_dp", bus_d.dp_out, 4'b0100);
    drive(4'b1111, 8'h80);
    step(20);
    drive(4'b1100, 8'h80);
    step(20);
    chk("nocap_hex", {bus_d.hex3, bus_d.hex2, bus_d.hex1, bus_d.hex0}, 16'h1210);
    chk("nocap_flags", {bus_d.digit_valid, bus_d.bad_code}, 8'hF0);
    chk("stall_s_set", bus_s.stall, 1'b1);
    chk("stall_d_clear", bus_d.stall, 1'b0);
    drive(4'b1110, 8'hC0);
    step(4);
    chk("stall_hold", bus_s.stall, 1'b1);
    step(1);
    chk("stall_drop", bus_s.stall, 1'b0);

    // Stall onset after exactly 15 capture-free cycles.
    do_reset();
    drive(4'b1111, 8'hFF);
    chk("post_rst_valid", bus_d.digit_valid, 4'b0000);
    step(14);
    chk("stall_14", bus_s.stall, 1'b0);
    step(1);
    chk("stall_15", bus_s.stall, 1'b1);

    // Reset mid-frame discards the partial frame.
    fd0 = fd_cnt;
    for (int s = 0; s < 2; s++) begin drive(scan_an[s], scan_seg[s]); step(8); end
    chk("mid_valid", bus_d.digit_valid, 4'b0011);
    do_reset();
    chk("mid_rst_valid", bus_d.digit_valid, 4'b0000);
    chk("mid_rst_hex", {bus_d.hex1, bus_d.hex0}, 8'h00);
    for (int s = 2; s < 4; s++) begin drive(scan_an[s], scan_seg[s]); step(8); end
    chk("mid_no_fd", fd_cnt - fd0, 0);
    chk("mid_valid2", bus_d.digit_valid, 4'b1100);

    // Random scan traffic.
    for (int t = 0; t < 300; t++) begin
      int pick;
      logic [3:0] a;
      logic [7:0] s;
      pick = $urandom_range(0, 9);
      if (pick < 6) begin
        a = 4'hF;
        a[$urandom_range(0, 3)] = 1'b0;
      end else if (pick == 6) a = 4'hF;
      else a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 7) s = {1'($urandom_range(0, 1)), glyphs[$urandom_range(0, 15)]};
      else s = 8'($urandom_range(0, 255));
      drive(a, s);
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(1, 8));
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
